// File: rtl/assert_stim_gen.sv
// Directed stimulus generator for the assertion-control checker: bursts of a |=> b transactions
// plus c/d pairs, with programmable violation injection and issued/violation counters.
module assert_stim_gen #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [7:0]       burst_len,
  input  logic [7:0]       viol_gap,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             start_sim,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StArm, StDrvA, StDrvB, StGap, StDone} state_e;

  localparam logic [3:0] GapLoad = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       vgap_q, vgap_d;
  logic [CNT_W-1:0] count1_q, count1_d;
  logic [CNT_W-1:0] count2_q, count2_d;
  logic             viol;

  // Violation flag for the transaction currently being driven; the guard avoids a modulo by zero.
  assign viol = (vgap_q != 8'd0) && ((idx_q % vgap_q) == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      gap_cnt_q <= '0;
      mode_q    <= '0;
      len_q     <= '0;
      vgap_q    <= '0;
      count1_q  <= '0;
      count2_q  <= '0;
    end else begin
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      vgap_q    <= vgap_d;
      count1_q  <= count1_d;
      count2_q  <= count2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    mode_d    = mode_q;
    len_d     = len_q;
    vgap_d    = vgap_q;
    count1_d  = count1_q;
    count2_d  = count2_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StArm;
          mode_d   = mode;
          len_d    = burst_len;
          vgap_d   = viol_gap;
          idx_d    = '0;
          count1_d = '0;
          count2_d = '0;
        end
      end
      StArm: begin
        if (len_q == 8'd0) begin
          state_d = StDone;
        end else begin
          idx_d   = 8'd1;
          state_d = StDrvA;
        end
      end
      StDrvA: state_d = StDrvB;
      StDrvB: begin
        // Counters commit on the edge ending DRV_B even if abort lands in the same cycle.
        if (!(viol && mode_q[0]) && (count1_q != '1)) count1_d = count1_q + 1'b1;
        if (viol && (mode_q != 2'd0) && (count2_q != '1)) count2_d = count2_q + 1'b1;
        if (idx_q == len_q) begin
          state_d = StDone;
        end else if (GAP_CYCLES == 0) begin
          idx_d   = idx_q + 8'd1;
          state_d = StDrvA;
        end else begin
          gap_cnt_d = GapLoad;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          idx_d   = idx_q + 8'd1;
          state_d = StDrvA;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    a         = (state_q == StDrvA);
    c         = (state_q == StDrvA);
    d         = (state_q == StDrvA) && !(viol && mode_q[1]);
    b         = (state_q == StDrvB) && !(viol && mode_q[0]);
    start_sim = (state_q == StArm);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    count1    = count1_q;
    count2    = count2_q;
  end

endmodule

// File: tb/tb_assert_stim_gen.sv
// Scoreboard bench for assert_stim_gen: expected per-cycle output traces and final counts are
// queued when a burst is launched and popped as the DUT runs.
module tb_assert_stim_gen;

  localparam int unsigned G  = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [7:0]    burst_len;
  logic [7:0]    viol_gap;
  logic          a, b, c, d, start_sim, busy, done;
  logic [CW-1:0] count1, count2;

  int errors = 0;
  int checks = 0;

  // Per-cycle expectation {a,b,c,d,start_sim,busy,done}; counts packed {count1,count2}.
  logic [6:0]      exp_q[$];
  logic [2*CW-1:0] cnt_q[$];

  assert_stim_gen #(
    .GAP_CYCLES(G),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .burst_len(burst_len),
    .viol_gap (viol_gap),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .start_sim(start_sim),
    .count1   (count1),
    .count2   (count2),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {a, b, c, d, start_sim, busy, done};
  endfunction

  function automatic logic [CW-1:0] sat(input int n);
    return (n > 15) ? 4'hF : CW'(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push_burst(input logic [1:0] m, input int len, input int vg);
    int  n1 = 0;
    int  n2 = 0;
    bit  v;
    exp_q.push_back(7'b0000110);
    for (int k = 1; k <= len; k++) begin
      v = (vg != 0) && (k % vg == 0);
      exp_q.push_back({1'b1, 1'b0, 1'b1, !(v && m[1]), 3'b010});
      exp_q.push_back({1'b0, !(v && m[0]), 2'b00, 3'b010});
      if (!(v && m[0])) n1++;
      if (v && m != 2'd0) n2++;
      if (k < len) for (int g = 0; g < int'(G); g++) exp_q.push_back(7'b0000010);
    end
    exp_q.push_back(7'b0000011);
    exp_q.push_back(7'b0000000);
    cnt_q.push_back({sat(n1), sat(n2)});
  endtask

  task automatic drive_start(input logic [1:0] m, input logic [7:0] len, input logic [7:0] vg);
    @(posedge clk);
    #1;
    mode      = m;
    burst_len = len;
    viol_gap  = vg;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    mode      = ~m;
    burst_len = ~len;
    viol_gap  = vg + 8'd1;
  endtask

  task automatic drain(input string tag, input bit noise, input int abort_at);
    int              i = 0;
    logic [6:0]      e;
    logic [2*CW-1:0] ec;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s.cyc%0d", tag, i + 1), 32'(obs()), 32'(e));
      start = noise && (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      abort = (i == abort_at);
      i++;
    end
    start = 1'b0;
    abort = 1'b0;
    ec = cnt_q.pop_front();
    check({tag, ".count1"}, 32'(count1), 32'(ec[2*CW-1:CW]));
    check({tag, ".count2"}, 32'(count2), 32'(ec[CW-1:0]));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    abort     = 1'b0;
    mode      = 2'd0;
    burst_len = 8'd3;
    viol_gap  = 8'd2;

    // Reset held with start high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset.outs", 32'(obs()), 32'd0);
      check("reset.count1", 32'(count1), 32'd0);
      check("reset.count2", 32'(count2), 32'd0);
    end

    // LEGAL len 3: start accepted on the first edge after reset release.
    push_burst(2'd0, 3, 2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'd3;
    drain("legal3", 1'b0, -1);

    push_burst(2'd1, 4, 2);
    drive_start(2'd1, 8'd4, 8'd2);
    drain("abviol4", 1'b1, -1);

    push_burst(2'd3, 3, 3);
    drive_start(2'd3, 8'd3, 8'd3);
    drain("both3", 1'b0, -1);

    push_burst(2'd3, 3, 0);
    drive_start(2'd3, 8'd3, 8'd0);
    drain("both3_nogap", 1'b0, -1);

    push_burst(2'd2, 0, 1);
    drive_start(2'd2, 8'd0, 8'd1);
    drain("len0", 1'b0, -1);

    push_burst(2'd2, 5, 2);
    drive_start(2'd2, 8'd5, 8'd2);
    drain("cdviol5", 1'b1, -1);

    // Abort during the first DRV_B of a 5-transaction burst.
    exp_q.push_back(7'b0000110);
    exp_q.push_back(7'b1011010);
    exp_q.push_back(7'b0100010);
    exp_q.push_back(7'b0000000);
    exp_q.push_back(7'b0000000);
    cnt_q.push_back({4'd1, 4'd0});
    drive_start(2'd0, 8'd5, 8'd0);
    drain("abort", 1'b0, 2);

    // abort beats start in IDLE.
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_start_idle.outs", 32'(obs()), 32'd0);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_start_idle.outs2", 32'(obs()), 32'd0);
    check("abort_start_idle.count1", 32'(count1), 32'd1);

    // A fresh start clears the counters; start pulses while busy are ignored.
    push_burst(2'd1, 2, 1);
    drive_start(2'd1, 8'd2, 8'd1);
    drain("after_abort", 1'b1, -1);

    // Counter saturation.
    push_burst(2'd0, 20, 0);
    drive_start(2'd0, 8'd20, 8'd0);
    drain("sat_count1", 1'b0, -1);

    push_burst(2'd1, 20, 1);
    drive_start(2'd1, 8'd20, 8'd1);
    drain("sat_count2", 1'b0, -1);

    // Asynchronous reset in the middle of a GAP.
    drive_start(2'd0, 8'd3, 8'd0);
    repeat (4) @(negedge clk);
    check("pre_reset.count1", 32'(count1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset.outs", 32'(obs()), 32'd0);
    check("async_reset.count1", 32'(count1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset.outs", 32'(obs()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
